gpio_input_debounce: RTL and testbench

- Conditions the board's asynchronous push-button and slide-switch inputs before they reach the processing-system block design's GPIO inputs.
- Sits between the top-level input pins (4 buttons, 2 switches) and the system block.
- Synchronises each bit, filters contact bounce, and emits clean levels, one-cycle edge pulses and a sticky change flag suitable for a GPIO interrupt line.

---
 rtl/gpio_cond_pkg.sv | 21 ++
 rtl/debounce_bit.sv | 86 ++++++++
 rtl/gpio_input_debounce.sv | 82 ++++++++
 tb/tb_gpio_input_debounce.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// Purpose: shared constants and helpers for the GPIO input conditioning block.
// Latency: n/a (package only).
// Backpressure: n/a (no datapath; the board pins cannot be stalled).
package gpio_cond_pkg;

    // 10 ms of stable level at a 100 MHz fabric clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Board input map: buttons occupy the low bits, slide switches sit above them
    localparam int BTN_BITS = 4;
    localparam int SW_BITS  = 2;
    localparam int BTN_LSB  = 0;
    localparam int SW_LSB   = 4;

    // Counter width for a terminal count of value-1. Never returns 0, so a
    // counter declared with it always has at least one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Purpose: one-bit synchroniser, bounce filter and accepted-edge pulse generator.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clock edges from the first sampling edge of a clean step to level_o.
// Backpressure: none; a new level is accepted once it has been stable long enough.
//
// Ports:
//   clk, rst  - fabric clock, asynchronous active-high reset
//   raw_i     - unsynchronised pin level
//   level_o   - debounced level (registered)
//   rise_o    - one-cycle pulse, coincident with level_o going 0->1
//   fall_o    - one-cycle pulse, coincident with level_o going 1->0
module debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   CNT_W           = clog2_min1(DEBOUNCE_CYCLES),
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    logic s;
    logic differs;

    // Plain shift chain: nothing may sit between synchroniser stages.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign s       = sync_q[SYNC_STAGES-1];
    assign differs = s ^ level_q;

    // The counter only advances while the synchronised input disagrees with
    // the accepted level; the terminal compare fires at DEBOUNCE_CYCLES-1, so
    // the counter never reaches a value that would overflow CNT_W.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!differs) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser loads the reset level so that releasing reset with the pin
    // already at that level produces no spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_VALUE}};
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_input_debounce.sv
// Purpose: conditions board buttons/switches into clean GPIO levels, edge pulses and a sticky interrupt flag.
// Latency: level/rise/fall after SYNC_STAGES+DEBOUNCE_CYCLES edges; edge_latched_o/change_o one edge later.
// Backpressure: none; sticky flags hold until clr_i, and an edge arriving with clr_i wins.
//
// Ports:
//   clk, rst        - fabric clock, asynchronous active-high reset (release expected synchronous to clk)
//   raw_i           - unsynchronised pin levels, buttons in [3:0], switches in [5:4]
//   irq_en_i        - per-bit enable for contributing to change_o
//   clr_i           - one-cycle pulse clearing edge_latched_o and change_o
//   level_o         - debounced levels for the system GPIO inputs
//   rise_o, fall_o  - one-cycle pulses on accepted transitions
//   edge_latched_o  - sticky per-bit record of accepted edges
//   change_o        - sticky OR of enabled accepted edges (interrupt request)
module gpio_input_debounce
    import gpio_cond_pkg::*;
#(
    parameter int               WIDTH           = BTN_BITS + SW_BITS,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int               CNT_W           = clog2_min1(DEBOUNCE_CYCLES),
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    input  logic [WIDTH-1:0] irq_en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] edge_latched_o,
    output logic             change_o
);

    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] edge_w;

    logic [WIDTH-1:0] edge_latched_q, edge_latched_d;
    logic             change_q, change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_debounce_bit (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw_i[i]),
            .level_o (level_o[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i])
        );
    end

    assign edge_w = rise_w | fall_w;

    // Clear first, then OR in this cycle's edges, so an edge coincident with
    // clr_i is never lost. irq_en_i only gates new edges into change_o.
    always_comb begin
        edge_latched_d = (clr_i ? '0 : edge_latched_q) | edge_w;
        change_d       = (clr_i ? 1'b0 : change_q) | (|(edge_w & irq_en_i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_latched_q <= '0;
            change_q       <= 1'b0;
        end else begin
            edge_latched_q <= edge_latched_d;
            change_q       <= change_d;
        end
    end

    assign rise_o         = rise_w;
    assign fall_o         = fall_w;
    assign edge_latched_o = edge_latched_q;
    assign change_o       = change_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Purpose: self-checking bench for gpio_input_debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Latency: expected pulses are queued at stimulus time for the cycle they must appear in.
// Backpressure: n/a.
module tb_gpio_input_debounce;

    localparam int W   = 6;
    localparam int LAT = 6; // SYNC_STAGES + DEBOUNCE_CYCLES

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_i = '0;
    logic [W-1:0] irq_en_i = '0;
    logic         clr_i = 1'b0;
    logic [W-1:0] level_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic [W-1:0] edge_latched_o;
    logic         change_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int           cyc;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } ev_t;

    ev_t exp_q[$];

    gpio_input_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (6'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .raw_i          (raw_i),
        .irq_en_i       (irq_en_i),
        .clr_i          (clr_i),
        .level_o        (level_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .edge_latched_o (edge_latched_o),
        .change_o       (change_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every pulse must match the oldest queued event,
    // and an event whose cycle has passed without a pulse is a miss.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                ev_t m;
                m = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d expected at %0d rise=%h fall=%h", cyc, m.cyc, m.rise, m.fall);
            end
            if ((rise_o | fall_o) != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d rise=%h fall=%h", cyc, rise_o, fall_o);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc !== cyc || e.rise !== rise_o || e.fall !== fall_o) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                                 cyc, rise_o, fall_o, e.cyc, e.rise, e.fall);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic at_post();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        at_post();
        clr_i = 1'b1;
        at_post();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw_i = '0;
        irq_en_i = '0;
        clr_i = 1'b0;
        repeat (3) at_post();
        checks++;
        if (level_o !== 6'h00 || rise_o !== 6'h00 || fall_o !== 6'h00 ||
            edge_latched_o !== 6'h00 || change_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state level=%h rise=%h fall=%h latched=%h change=%b required all 0",
                     level_o, rise_o, fall_o, edge_latched_o, change_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (level_o !== 6'h00 || change_o !== 1'b0 || edge_latched_o !== 6'h00) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d level=%h change=%b latched=%h required 0",
                         cyc, level_o, change_o, edge_latched_o);
            end
        end
    endtask

    task automatic test_step();
        int t;
        irq_en_i = 6'h3F;
        at_post();
        t = cyc;
        raw_i[0] = 1'b1;
        exp_q.push_back('{t + LAT, 6'h01, 6'h00});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (level_o[0] !== (cyc >= t + LAT)) begin
                errors++;
                $display("FAIL step_level cyc=%0d level0=%b required %b", cyc, level_o[0], (cyc >= t + LAT));
            end
            if (cyc == t + LAT) begin
                checks++;
                if (change_o !== 1'b0) begin
                    errors++;
                    $display("FAIL step_change_early cyc=%0d change=%b required 0", cyc, change_o);
                end
            end
            if (cyc == t + LAT + 1) begin
                checks++;
                if (change_o !== 1'b1 || edge_latched_o !== 6'h01) begin
                    errors++;
                    $display("FAIL step_sticky cyc=%0d change=%b latched=%h required 1 01",
                             cyc, change_o, edge_latched_o);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int k;
        for (int rep = 0; rep < 5; rep++) begin
            at_post();
            raw_i[1] = 1'b1;
            repeat (3) at_post();
            raw_i[1] = 1'b0;
            repeat (3) at_post();
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (level_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_level cyc=%0d level1=%b required 0", cyc, level_o[1]);
            end
        end
        // A pulse one cycle longer than the rejection limit is accepted.
        at_post();
        k = cyc;
        raw_i[1] = 1'b1;
        exp_q.push_back('{k + LAT, 6'h02, 6'h00});
        repeat (4) at_post();
        raw_i[1] = 1'b0;
        exp_q.push_back('{k + 4 + LAT, 6'h00, 6'h02});
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (level_o[1] !== (cyc >= k + LAT && cyc < k + 4 + LAT)) begin
                errors++;
                $display("FAIL min_pulse_level cyc=%0d level1=%b required %b",
                         cyc, level_o[1], (cyc >= k + LAT && cyc < k + 4 + LAT));
            end
        end
    endtask

    task automatic test_simultaneous();
        int t;
        clear_flags();
        @(negedge clk);
        checks++;
        if (change_o !== 1'b0 || edge_latched_o !== 6'h00) begin
            errors++;
            $display("FAIL clear_before_sim change=%b latched=%h required 0 00", change_o, edge_latched_o);
        end
        irq_en_i = 6'h10;
        at_post();
        t = cyc;
        raw_i[5:4] = 2'b11;
        exp_q.push_back('{t + LAT, 6'h30, 6'h00});
        repeat (LAT + 1) at_post();
        checks++;
        if (edge_latched_o !== 6'h30 || change_o !== 1'b1 || level_o !== 6'h31) begin
            errors++;
            $display("FAIL sim_sticky latched=%h change=%b level=%h required 30 1 31",
                     edge_latched_o, change_o, level_o);
        end
        clear_flags();
        @(negedge clk);
        checks++;
        if (change_o !== 1'b0 || edge_latched_o !== 6'h00) begin
            errors++;
            $display("FAIL sim_clear change=%b latched=%h required 0 00", change_o, edge_latched_o);
        end
    endtask

    task automatic test_irq_mask();
        int t;
        irq_en_i = 6'h00;
        at_post();
        t = cyc;
        raw_i[5:4] = 2'b00;
        exp_q.push_back('{t + LAT, 6'h00, 6'h30});
        repeat (LAT + 1) at_post();
        checks++;
        if (edge_latched_o !== 6'h30 || change_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_mask latched=%h change=%b required 30 0", edge_latched_o, change_o);
        end
        clear_flags();
    endtask

    task automatic test_clr_collide();
        int t;
        int t2;
        irq_en_i = 6'h04;
        at_post();
        t = cyc;
        raw_i[2] = 1'b1;
        exp_q.push_back('{t + LAT, 6'h04, 6'h00});
        repeat (LAT + 2) at_post();
        checks++;
        if (change_o !== 1'b1 || edge_latched_o !== 6'h04) begin
            errors++;
            $display("FAIL collide_setup change=%b latched=%h required 1 04", change_o, edge_latched_o);
        end
        at_post();
        t2 = cyc;
        raw_i[2] = 1'b0;
        exp_q.push_back('{t2 + LAT, 6'h00, 6'h04});
        repeat (LAT) at_post();
        clr_i = 1'b1; // same cycle as fall_o[2]
        at_post();
        clr_i = 1'b0;
        @(negedge clk);
        checks++;
        if (change_o !== 1'b1 || edge_latched_o !== 6'h04) begin
            errors++;
            $display("FAIL clr_collide change=%b latched=%h required 1 04", change_o, edge_latched_o);
        end
    endtask

    task automatic test_reset_midcount();
        int t;
        int r;
        at_post();
        t = cyc;
        raw_i[3] = 1'b1;
        repeat (4) at_post();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (level_o !== 6'h00 || rise_o !== 6'h00 || fall_o !== 6'h00 ||
            edge_latched_o !== 6'h00 || change_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset level=%h rise=%h fall=%h latched=%h change=%b required all 0",
                     level_o, rise_o, fall_o, edge_latched_o, change_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_before_reset size=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) at_post();
        r = cyc;
        rst = 1'b0;
        // raw_i[0] and raw_i[3] are both high, so both rise after the full latency.
        exp_q.push_back('{r + LAT, 6'h09, 6'h00});
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (level_o[3] !== (cyc >= r + LAT)) begin
                errors++;
                $display("FAIL restart_level cyc=%0d level3=%b required %b", cyc, level_o[3], (cyc >= r + LAT));
            end
        end
        checks++;
        if (t + 4 >= r) begin
            errors++;
            $display("FAIL reset_ordering t=%0d r=%0d", t, r);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_simultaneous();
        test_irq_mask();
        test_clr_collide();
        test_reset_midcount();
        repeat (4) at_post();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected size=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
